// File: rtl/sid_regbank_multi.sv
// sid_regbank_multi
//   SID-style CPU register bank for NUM_VOICES voices plus the filter block.
//   Decodes CPU reads/writes, divides clk32 down to the voice-rate enable
//   voice_tick, and presents a tick-aligned shadow copy of every voice and
//   filter register to the datapaths. A gate pulse shorter than one tick is
//   stretched so the voice still sees gate=1 for one tick.
//
//   Optional feature: define SID_BUS_DECAY_EN to make the CPU bus latch decay
//   to 0 after DECAY_TICKS voice ticks without a write.
//
// Ports
//   clk32        system clock
//   reset_n      asynchronous reset, active low
//   cs, we       chip select / write enable (cs & we = write, cs & ~we = read)
//   addr         register address (ADDR_W bits)
//   data_in      write data
//   data_out     registered read data, valid one cycle after the read
//   pot_x/pot_y  paddle inputs, returned by the read-only registers
//   osc3/env3    last-voice readback inputs, returned by the read-only registers
//   voice_tick   one-cycle enable, every CLK_DIV cycles
//   voice_regs   shadow voice registers, voice i at [52*i +: 52] =
//                {sr, ad, ctrl, pw[11:0], freq[15:0]}
//   filter_regs  shadow filter registers {mode_vol, res_filt, fc_hi, fc_lo}
module sid_regbank_multi #(
    parameter int NUM_VOICES  = 3,
    parameter int ADDR_W      = 5,
    parameter int CLK_DIV     = 32,
    parameter int DECAY_TICKS = 8192
) (
    input  logic                    clk32,
    input  logic                    reset_n,
    input  logic                    cs,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [7:0]              data_in,
    output logic [7:0]              data_out,
    input  logic [7:0]              pot_x,
    input  logic [7:0]              pot_y,
    input  logic [7:0]              osc3,
    input  logic [7:0]              env3,
    output logic                    voice_tick,
    output logic [52*NUM_VOICES-1:0] voice_regs,
    output logic [31:0]             filter_regs
);

    localparam int F_BASE = 7 * NUM_VOICES;
    localparam int DIV_W  = $clog2(CLK_DIV);

    // Elaboration-time guard against parameter sets the address map cannot hold.
    if (NUM_VOICES < 1 || NUM_VOICES > 4 || CLK_DIV < 2 || DECAY_TICKS < 1 ||
        (1 << ADDR_W) <= (7 * NUM_VOICES + 7)) begin : g_param_check
        $error("sid_regbank_multi: illegal parameter combination");
    end

    logic wr_en;
    logic rd_en;
    assign wr_en = cs & we;
    assign rd_en = cs & ~we;

    // ------------------------------------------------------------------
    // Voice-rate tick divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_reg;

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_reg <= '0;
        end else if (div_cnt_reg == DIV_W'(CLK_DIV - 1)) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    assign voice_tick = (div_cnt_reg == DIV_W'(CLK_DIV - 1));

    // ------------------------------------------------------------------
    // Per-voice live registers, gate capture and shadow
    // ------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        localparam int VB = 7 * gi;

        logic [7:0]  freq_lo_reg, freq_hi_reg, pw_lo_reg;
        logic [3:0]  pw_hi_reg;
        logic [7:0]  ctrl_reg, ad_reg, sr_reg;
        logic        gate_pend_reg;
        logic [51:0] shadow_reg;
        logic        ctrl_wr;
        logic        gate_set;

        assign ctrl_wr  = wr_en && (addr == ADDR_W'(VB + 4));
        // Only a rising gate edge arms the pend; re-writing gate=1 does not.
        assign gate_set = ctrl_wr && data_in[0] && !ctrl_reg[0];

        always_ff @(posedge clk32 or negedge reset_n) begin
            if (!reset_n) begin
                freq_lo_reg <= '0;
                freq_hi_reg <= '0;
                pw_lo_reg   <= '0;
                pw_hi_reg   <= '0;
                ctrl_reg    <= '0;
                ad_reg      <= '0;
                sr_reg      <= '0;
            end else if (wr_en) begin
                if (addr == ADDR_W'(VB + 0)) freq_lo_reg <= data_in;
                if (addr == ADDR_W'(VB + 1)) freq_hi_reg <= data_in;
                if (addr == ADDR_W'(VB + 2)) pw_lo_reg   <= data_in;
                if (addr == ADDR_W'(VB + 3)) pw_hi_reg   <= data_in[3:0];
                if (ctrl_wr)                 ctrl_reg    <= data_in;
                if (addr == ADDR_W'(VB + 5)) ad_reg      <= data_in;
                if (addr == ADDR_W'(VB + 6)) sr_reg      <= data_in;
            end
        end

        // A rising-gate write in the tick cycle wins over the tick's clear,
        // so that pend is serviced at the following tick.
        always_ff @(posedge clk32 or negedge reset_n) begin
            if (!reset_n) begin
                gate_pend_reg <= 1'b0;
            end else if (gate_set) begin
                gate_pend_reg <= 1'b1;
            end else if (voice_tick) begin
                gate_pend_reg <= 1'b0;
            end
        end

        // Shadow samples the pre-edge live values, so a write in the tick
        // cycle is picked up only at the next tick.
        always_ff @(posedge clk32 or negedge reset_n) begin
            if (!reset_n) begin
                shadow_reg <= '0;
            end else if (voice_tick) begin
                shadow_reg <= {sr_reg, ad_reg, ctrl_reg[7:1],
                               ctrl_reg[0] | gate_pend_reg,
                               pw_hi_reg, pw_lo_reg, freq_hi_reg, freq_lo_reg};
            end
        end

        assign voice_regs[52*gi +: 52] = shadow_reg;
    end

    // ------------------------------------------------------------------
    // Filter live registers and shadow
    // ------------------------------------------------------------------
    logic [7:0]  fc_lo_reg, fc_hi_reg, res_filt_reg, mode_vol_reg;
    logic [31:0] filter_shadow_reg;

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            fc_lo_reg    <= '0;
            fc_hi_reg    <= '0;
            res_filt_reg <= '0;
            mode_vol_reg <= '0;
        end else if (wr_en) begin
            if (addr == ADDR_W'(F_BASE + 0)) fc_lo_reg    <= data_in;
            if (addr == ADDR_W'(F_BASE + 1)) fc_hi_reg    <= data_in;
            if (addr == ADDR_W'(F_BASE + 2)) res_filt_reg <= data_in;
            if (addr == ADDR_W'(F_BASE + 3)) mode_vol_reg <= data_in;
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            filter_shadow_reg <= '0;
        end else if (voice_tick) begin
            filter_shadow_reg <= {mode_vol_reg, res_filt_reg, fc_hi_reg, fc_lo_reg};
        end
    end

    assign filter_regs = filter_shadow_reg;

    // ------------------------------------------------------------------
    // Bus latch: every write loads it, reads of writable/unmapped
    // addresses return it.
    // ------------------------------------------------------------------
    logic [7:0] bus_latch_reg;

`ifdef SID_BUS_DECAY_EN
    localparam int DCNT_W = $clog2(DECAY_TICKS + 1);
    logic [DCNT_W-1:0] decay_cnt_reg;
    logic              decay_done;

    assign decay_done = (decay_cnt_reg == DCNT_W'(DECAY_TICKS));

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            decay_cnt_reg <= '0;
        end else if (wr_en) begin
            decay_cnt_reg <= '0;
        end else if (voice_tick && !decay_done) begin
            decay_cnt_reg <= decay_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            bus_latch_reg <= '0;
        end else if (wr_en) begin
            bus_latch_reg <= data_in;
        end else if (decay_done) begin
            bus_latch_reg <= '0;
        end
    end
`else
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            bus_latch_reg <= '0;
        end else if (wr_en) begin
            bus_latch_reg <= data_in;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [7:0] rd_data;
    logic [7:0] data_out_reg;

    always_comb begin
        rd_data = bus_latch_reg;
        if      (addr == ADDR_W'(F_BASE + 4)) rd_data = pot_x;
        else if (addr == ADDR_W'(F_BASE + 5)) rd_data = pot_y;
        else if (addr == ADDR_W'(F_BASE + 6)) rd_data = osc3;
        else if (addr == ADDR_W'(F_BASE + 7)) rd_data = env3;
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            data_out_reg <= '0;
        end else if (rd_en) begin
            data_out_reg <= rd_data;
        end
    end

    assign data_out = data_out_reg;

endmodule
